// File: rtl/demux_pkg.sv
// Shared constants and the lane-group decode for the 1-to-16 pipelined demux.
// Optional feature macro used by the design: DEMUX_BROADCAST_EN.
package demux_pkg;

   localparam int LANES       = 16;
   localparam int SEL_W       = 4;
   localparam int GROUPS      = 4;
   localparam int GROUP_SEL_W = 2;

   // One-hot decode of the upper select bits into one of four lane groups.
   function automatic logic [GROUPS-1:0] group_onehot(input logic [GROUP_SEL_W-1:0] grp);
      logic [GROUPS-1:0] oh;
      oh      = '0;
      oh[grp] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_lane_slot.sv
// One output lane of the demux: data register, valid bit, accept logic.
// The lane holds its word and valid bit steady until the consumer takes it.
module demux_lane_slot #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             out_ready_i,
   output logic             can_accept_o,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Lane is free when empty or when its current word leaves this cycle.
   assign can_accept_o = !valid_q || out_ready_i;

   // Load wins over a departing word; otherwise hold unless the consumer takes it.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Lane state register; data is kept after delivery and zeroed only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/demux_1x16_pipelined.sv
// Two-stage pipelined 1-to-16 demux. Stage 1 holds one decoded word; stage 2
// is sixteen lane slots. Optional macro: DEMUX_BROADCAST_EN adds a broadcast
// input that delivers one word to every lane at once.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Input side: in_valid/in_ready; lane k: out_valid[k]/out_ready[k]. A
// producer holding valid keeps its payload stable; ready may depend
// combinationally on the opposite side's ready (in_ready follows out_ready).
module demux_1x16_pipelined
   import demux_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       DATA,
   input  logic [SEL_W-1:0]       SELECT,
`ifdef DEMUX_BROADCAST_EN
   input  logic                   broadcast,
`endif
   output logic [LANES*WIDTH-1:0] OUT,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready
);

   logic                   s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]       s1_data_q, s1_data_d;
   logic [GROUP_SEL_W-1:0] s1_lo_q, s1_lo_d;
   logic [GROUPS-1:0]      s1_grp_q, s1_grp_d;
`ifdef DEMUX_BROADCAST_EN
   logic                   s1_bcast_q, s1_bcast_d;
`endif

   logic             in_fire;
   logic             s1_advance;
   logic [LANES-1:0] lane_tgt;
   logic [LANES-1:0] lane_can;
   logic [LANES-1:0] lane_load;

   // Lane k is targeted when its group bit is set and the low select bits match.
   for (genvar k = 0; k < LANES; k++) begin : g_tgt
      localparam int GRP = k / GROUPS;
      localparam int SUB = k % GROUPS;
      assign lane_tgt[k] = s1_grp_q[GRP] && (s1_lo_q == GROUP_SEL_W'(SUB));
   end

   // Decide whether the stage-1 word can move into its lane(s) this cycle.
   always_comb begin
      s1_advance = 1'b0;
      lane_load  = '0;
`ifdef DEMUX_BROADCAST_EN
      if (s1_bcast_q) begin
         s1_advance = s1_valid_q && (&lane_can);
         lane_load  = {LANES{s1_advance}};
      end else begin
         s1_advance = s1_valid_q && (|(lane_tgt & lane_can));
         lane_load  = s1_advance ? lane_tgt : '0;
      end
`else
      s1_advance = s1_valid_q && (|(lane_tgt & lane_can));
      lane_load  = s1_advance ? lane_tgt : '0;
`endif
   end

   // Single stage-1 slot keeps words strictly in order: a stalled lane blocks all.
   assign in_ready = !s1_valid_q || s1_advance;
   assign in_fire  = in_valid && in_ready;

   // Stage-1 next state: capture on input transfer, empty on advance.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_lo_d    = s1_lo_q;
      s1_grp_d   = s1_grp_q;
`ifdef DEMUX_BROADCAST_EN
      s1_bcast_d = s1_bcast_q;
`endif
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_data_d  = DATA;
         s1_lo_d    = SELECT[GROUP_SEL_W-1:0];
         s1_grp_d   = group_onehot(SELECT[SEL_W-1:GROUP_SEL_W]);
`ifdef DEMUX_BROADCAST_EN
         s1_bcast_d = broadcast;
`endif
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage-1 register; reset drops any pending word.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_lo_q    <= '0;
         s1_grp_q   <= '0;
`ifdef DEMUX_BROADCAST_EN
         s1_bcast_q <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_lo_q    <= s1_lo_d;
         s1_grp_q   <= s1_grp_d;
`ifdef DEMUX_BROADCAST_EN
         s1_bcast_q <= s1_bcast_d;
`endif
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      demux_lane_slot #(.WIDTH(WIDTH)) u_slot (
         .clk          (clk),
         .rst          (rst),
         .load_i       (lane_load[k]),
         .data_i       (s1_data_q),
         .out_ready_i  (out_ready[k]),
         .can_accept_o (lane_can[k]),
         .data_o       (OUT[k*WIDTH +: WIDTH]),
         .valid_o      (out_valid[k])
      );
   end

endmodule

// File: tb/tb_demux_1x16_pipelined.sv
// Self-checking bench for demux_1x16_pipelined: per-lane expected queues fed
// by the driver, popped by a monitor on every lane transfer.
module tb_demux_1x16_pipelined;

  localparam int W = 64;
  localparam int L = 16;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   data;
  logic [3:0]     sel;
`ifdef DEMUX_BROADCAST_EN
  logic           broadcast;
`endif
  logic [L*W-1:0] out_bus;
  logic [L-1:0]   out_valid;
  logic [L-1:0]   out_ready;

  demux_1x16_pipelined #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DATA      (data),
    .SELECT    (sel),
`ifdef DEMUX_BROADCAST_EN
    .broadcast (broadcast),
`endif
    .OUT       (out_bus),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q [L][$];
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           stall_cycles = 0;
  bit           mon_en       = 1'b0;
  bit           rand_rdy     = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    for (int k = 0; k < L; k++) exp_q[k].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one word and hold it until accepted; record the expected delivery.
  task automatic send(input logic [W-1:0] d, input logic [3:0] s, input bit b);
    int  waited;
    bit  accepted;
    waited   = 0;
    accepted = 1'b0;
    in_valid = 1'b1;
    data     = d;
    sel      = s;
`ifdef DEMUX_BROADCAST_EN
    broadcast = b;
`endif
    while (!accepted && waited < 500) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (b) begin
          for (int k = 0; k < L; k++) exp_q[k].push_back(d);
        end else begin
          exp_q[s].push_back(d);
        end
      end else begin
        waited++;
        stall_cycles++;
      end
      tick();
    end
    if (!accepted) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
    end
    in_valid = 1'b0;
`ifdef DEMUX_BROADCAST_EN
    broadcast = 1'b0;
`endif
  endtask

  // Wait until every expected word has been delivered (bounded).
  task automatic drain(input string name);
    int  n;
    int  pend;
    n = 0;
    do begin
      pend = 0;
      for (int k = 0; k < L; k++) pend += exp_q[k].size();
      if (pend != 0 || out_valid != '0) tick();
      n++;
    end while ((pend != 0 || out_valid != '0) && n < 1000);
    check({name, "_drained"}, W'(pend), W'(0));
  endtask

  // ---------------- monitor ----------------
  logic [L-1:0] held;
  logic [W-1:0] held_data [L];
  initial begin
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = '0;
      end else if (mon_en) begin
        for (int k = 0; k < L; k++) begin
          logic [W-1:0] lane;
          logic [W-1:0] e;
          lane = out_bus[k*W +: W];
          if (held[k]) begin
            check("hold_valid", W'(out_valid[k]), W'(1));
            check("hold_data", lane, held_data[k]);
          end
          held[k] = 1'b0;
          if (out_valid[k]) begin
            if (out_ready[k]) begin
              if (exp_q[k].size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL lane_spurious: lane %0d delivered %h with nothing expected", k, lane);
              end else begin
                e = exp_q[k].pop_front();
                check("lane_data", lane, e);
              end
            end else begin
              held[k]      = 1'b1;
              held_data[k] = lane;
            end
          end
        end
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = L'($urandom);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data      = '0;
    sel       = '0;
    out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
    broadcast = 1'b0;
`endif
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    for (int k = 0; k < L; k++) check("rst_out_zero", out_bus[k*W +: W], W'(0));
    tick();
    mon_en = 1'b1;

    // Single word to lane 7: visible exactly two cycles after the input cycle.
    out_ready = '1;
    w         = 64'hA5A5_0000_0000_0007;
    in_valid  = 1'b1;
    data      = w;
    sel       = 4'd7;
    @(negedge clk);
    check("lat_in_ready", W'(in_ready), W'(1));
    check("lat_c0_valid", W'(out_valid), W'(0));
    exp_q[7].push_back(w);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_valid", W'(out_valid), W'(0));
    tick();
    @(negedge clk);
    check("lat_c2_valid", W'(out_valid), W'(16'h0080));
    check("lat_c2_data", out_bus[7*W +: W], w);
    tick();
    @(negedge clk);
    check("lat_c3_valid", W'(out_valid), W'(0));
    check("lat_c3_keep", out_bus[7*W +: W], w);
    tick();

    // Sweep all lanes back-to-back: no stalls allowed.
    stall_cycles = 0;
    for (int k = 0; k < L; k++) send(W'(k), 4'(k), 1'b0);
    check("sweep_no_stall", W'(stall_cycles), W'(0));
    drain("sweep");

    // Two words to a blocked lane 3, then a word to idle lane 9.
    out_ready = 16'hFFF7;
    send(64'h3333_0000_0000_0001, 4'd3, 1'b0);
    send(64'h3333_0000_0000_0002, 4'd3, 1'b0);
    in_valid = 1'b1;
    data     = 64'h9999_0000_0000_0009;
    sel      = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", W'(in_ready), W'(0));
      check("stall_lane9_empty", W'(out_valid[9]), W'(0));
      tick();
    end
    out_ready = '1;
    @(negedge clk);
    check("recover_in_ready", W'(in_ready), W'(1));
    if (in_ready) exp_q[9].push_back(data);
    tick();
    in_valid = 1'b0;
    drain("stall");

    // Reset while stage 1 and lanes 2 and 5 hold words.
    out_ready = '0;
    send(64'h2222, 4'd2, 1'b0);
    send(64'h5555, 4'd5, 1'b0);
    send(64'h7777, 4'd7, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", W'(out_valid), W'(16'h0024));
    tick();
    rst = 1'b1;
    flush_model();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    for (int k = 0; k < L; k++) check("midrst_out_zero", out_bus[k*W +: W], W'(0));
    tick();
    repeat (3) tick();
    check("midrst_no_late", W'(out_valid), W'(0));

`ifdef DEMUX_BROADCAST_EN
    // Broadcast waits in s1 until the full lane 4 drains.
    out_ready = 16'hFFEF;
    send(64'h4444, 4'd4, 1'b0);
    out_ready = '0;
    send(64'h1, 4'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bc_wait_valid", W'(out_valid), W'(16'h0010));
      check("bc_wait_in_ready", W'(in_ready), W'(0));
      tick();
    end
    out_ready = 16'h0010;
    tick();
    out_ready = '0;
    @(negedge clk);
    check("bc_all_valid", W'(out_valid), W'(16'hFFFF));
    for (int k = 0; k < L; k++) check("bc_lane_data", out_bus[k*W +: W], W'(1));
    tick();
    out_ready = '1;
    drain("bcast");
`endif

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit b;
      b = 1'b0;
`ifdef DEMUX_BROADCAST_EN
      b = ($urandom_range(0, 15) == 0);
`endif
      send({$urandom, $urandom}, 4'($urandom_range(0, 15)), b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_rdy = 1'b0;
    tick();
    out_ready = '1;
    drain("random");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
